// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: power-on / soft reset sequencer for NUM_DOM reset domains.
// After reset it enables the clock tree, waits CLK_SETTLE cycles, then
// releases domains 0..NUM_DOM-1 one at a time. Each domain must ack before
// the next one is released (REL_GAP cycles after the ack). A soft request
// tears the domains down in descending order and re-runs the sequence.
//
// Optional feature: define RST_SEQ_TIMEOUT_EN to enable the ack timeout
// (TO_CYC cycles per domain). A timeout parks the FSM in ERR with err=1 and
// err_dom = index of the silent domain. When undefined, WAIT_ACK waits
// forever and err / err_dom are constant 0.
//
// Handshake semantics: dom_ack[i] is a level, sampled only while the FSM is
// in WAIT_ACK for domain i; the first rising clk edge that sees it high
// completes that domain. soft_rst_req is a level sampled every edge; a high
// sample outside DONE / ERR / ASSERT is remembered (pending) and acted on
// when the sequence reaches DONE. Inside ASSERT it is ignored and cleared.
module rst_seq_ctrl #(
  parameter int NUM_DOM    = 4,
  parameter int CLK_SETTLE = 8,
  parameter int REL_GAP    = 4,
  parameter int TO_CYC     = 64,
  localparam int IW        = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst_req,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic               clk_en,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_done,
  output logic               busy,
  output logic               err,
  output logic [IW-1:0]      err_dom,
  output logic [2:0]         dbg_state
);

  // Shared cycle counter for SETTLE, GAP and ASSERT; all limits fit 8 bits.
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_SETTLE   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4,
    S_ASSERT   = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  // Out-of-range parameters stop elaboration rather than mis-size counters.
  if (NUM_DOM < 1 || NUM_DOM > 16 || CLK_SETTLE < 1 || CLK_SETTLE > 255 ||
      REL_GAP < 1 || REL_GAP > 255 || TO_CYC < 1) begin : g_bad_param
    $error("rst_seq_ctrl: parameter out of range");
  end

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic               r_pending;
  logic               r_clk_en;
  logic [NUM_DOM-1:0] r_dom_rst_n;
  logic               r_seq_done;
  logic               r_busy;

  logic [IW-1:0]      w_idx_inc;
  logic [IW-1:0]      w_asrt_bit;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TW-1:0]      r_to_cnt;
  logic               r_err;
  logic [IW-1:0]      r_err_dom;
`endif

  // Next domain to release from GAP, and the bit ASSERT clears this cycle
  // (descending from NUM_DOM-1 as r_cnt counts up from 0).
  assign w_idx_inc  = r_idx + IW'(1);
  assign w_asrt_bit = IW'(NUM_DOM - 1) - r_cnt[IW-1:0];

  // Sequencer FSM: all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_clk_en    <= 1'b0;
      r_dom_rst_n <= '0;
      r_seq_done  <= 1'b0;
      r_busy      <= 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
      r_err_dom   <= '0;
`endif
    end else begin
      // Remember a soft request made while the sequence is still running.
      if (soft_rst_req && (r_state inside {S_HOLD, S_SETTLE, S_WAIT_ACK, S_GAP})) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_HOLD: begin
          r_clk_en <= 1'b1;
          r_idx    <= '0;
          r_cnt    <= '0;
          r_state  <= S_SETTLE;
        end

        S_SETTLE: begin
          if (r_cnt == CW'(CLK_SETTLE - 1)) begin
            r_cnt              <= '0;
            r_dom_rst_n[r_idx] <= 1'b1;
            r_state            <= S_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
            r_to_cnt           <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_ACK: begin
          if (dom_ack[r_idx]) begin
            if (r_idx == IW'(NUM_DOM - 1)) begin
              r_state    <= S_DONE;
              r_seq_done <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_cnt   <= '0;
              r_state <= S_GAP;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (r_to_cnt == TW'(TO_CYC - 1)) begin
            r_state   <= S_ERR;
            r_err     <= 1'b1;
            r_err_dom <= r_idx;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
`endif
        end

        S_GAP: begin
          if (r_cnt == CW'(REL_GAP - 1)) begin
            r_cnt                  <= '0;
            r_idx                  <= w_idx_inc;
            r_dom_rst_n[w_idx_inc] <= 1'b1;
            r_state                <= S_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
            r_to_cnt               <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          if (r_pending || soft_rst_req) begin
            r_state    <= S_ASSERT;
            r_seq_done <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
          end
        end

        S_ASSERT: begin
          r_pending <= 1'b0;
          if (r_cnt == CW'(NUM_DOM)) begin
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_state  <= S_HOLD;
          end else begin
            r_dom_rst_n[w_asrt_bit] <= 1'b0;
            r_cnt                   <= r_cnt + CW'(1);
          end
        end

        S_ERR: begin
          if (soft_rst_req) begin
            r_state   <= S_ASSERT;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_pending <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= S_HOLD;
        end
      endcase
    end
  end

  assign clk_en    = r_clk_en;
  assign dom_rst_n = r_dom_rst_n;
  assign seq_done  = r_seq_done;
  assign busy      = r_busy;
  assign dbg_state = r_state;

`ifdef RST_SEQ_TIMEOUT_EN
  assign err     = r_err;
  assign err_dom = r_err_dom;
`else
  assign err     = 1'b0;
  assign err_dom = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: bench for rst_seq_ctrl at default parameters.
// The reference model derives release / ack / done / teardown edge numbers
// from per-domain ack delays and the soft request edge, then turns them into
// the expected output vector for every clock edge of a sequence.
module tb_rst_seq_ctrl;
  localparam int N      = 4;
  localparam int SETTLE = 8;
  localparam int GAP    = 4;
  localparam int TO     = 64;
  localparam int W      = N + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] dom_ack = '0;
  logic         clk_en;
  logic [N-1:0] dom_rst_n;
  logic         seq_done;
  logic         busy;
  logic         err;
  logic [1:0]   err_dom;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected {clk_en, seq_done, busy, dom_rst_n} per edge of a sequence.
  logic [W-1:0] exp_q[$];

  rst_seq_ctrl #(
    .NUM_DOM   (N),
    .CLK_SETTLE(SETTLE),
    .REL_GAP   (GAP),
    .TO_CYC    (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(soft_rst_req),
    .dom_ack     (dom_ack),
    .clk_en      (clk_en),
    .dom_rst_n   (dom_rst_n),
    .seq_done    (seq_done),
    .busy        (busy),
    .err         (err),
    .err_dom     (err_dom),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full sequence starting at the HOLD edge (t=0 is the edge that raises
  // clk_en) and ending at the edge that drops clk_en again. d[i] is the
  // number of edges from release of domain i to the edge sampling its ack.
  // soft_at is the edge carrying a one-cycle soft request; stop_at < 0 runs
  // to the end, otherwise the run returns right after that edge is checked.
  task automatic run_seq(input int d[N], input int soft_at, input int stop_at,
                         input string name);
    int rel[N];
    int ackt[N];
    int done_t, s0, last;
    logic         e_clk, e_done, e_busy;
    logic [N-1:0] e_rst;
    logic [W-1:0] exp_v, act_v;
    rel[0] = SETTLE;
    for (int i = 0; i < N; i++) begin
      ackt[i] = rel[i] + d[i];
      if (i < N - 1) rel[i+1] = ackt[i] + GAP;
    end
    done_t = ackt[N-1];
    s0     = (soft_at <= done_t) ? done_t + 1 : soft_at;
    last   = s0 + N + 1;
    exp_q.delete();
    for (int t = 0; t <= last; t++) begin
      e_clk  = (t < last);
      e_done = (t >= done_t) && (t < s0);
      e_busy = !e_done;
      for (int i = 0; i < N; i++) e_rst[i] = (t >= rel[i]) && (t < s0 + N - i);
      exp_q.push_back({e_clk, e_done, e_busy, e_rst});
    end
    for (int t = 0; t <= last; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t == ackt[i])                    dom_ack[i] = 1'b1;
        else if (t > rel[i] && t < ackt[i])  dom_ack[i] = 1'b0;
        else                                 dom_ack[i] = 1'($urandom_range(0, 1));
      end
      if (t == soft_at)              soft_rst_req = 1'b1;
      else if (t > s0 && t <= last)  soft_rst_req = 1'($urandom_range(0, 1));
      else                           soft_rst_req = 1'b0;
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      act_v = {clk_en, seq_done, busy, dom_rst_n};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s t=%0d {clk_en,seq_done,busy,dom_rst_n}: got %b want %b",
                 name, t, act_v, exp_v);
      end
      checks++;
      if ({err, err_dom} !== 3'b000) begin
        failures++;
        $display("FAIL %s t=%0d err/err_dom: got %b/%0d want 0/0", name, t, err, err_dom);
      end
      if (t == stop_at) break;
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({clk_en, dom_rst_n, seq_done, busy, err, err_dom} !== {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_values: got clk_en=%b rst_n=%b done=%b busy=%b err=%b err_dom=%0d want 0 0000 0 1 0 0",
               clk_en, dom_rst_n, seq_done, busy, err, err_dom);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_default_timing();
    run_seq('{1, 1, 1, 1}, 30, -1, "default_timing");
  endtask

  task automatic test_resequence();
    run_seq('{1, 1, 1, 1}, 26, -1, "resequence");
  endtask

  task automatic test_late_ack();
    run_seq('{1, 1, 20, 1}, 47, -1, "late_ack2");
  endtask

  task automatic test_soft_mid_seq();
    run_seq('{1, 1, 1, 1}, 10, -1, "soft_at_e10");
  endtask

  // Async reset mid-GAP (with a soft request already pending) and in DONE.
  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_seq('{1, 1, 1, 1}, 3, 11, "pre_reset_gap");
      else        run_seq('{2, 1, 3, 1}, 60, 29, "pre_reset_done");
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({clk_en, dom_rst_n, seq_done, busy, err, err_dom} !== {1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0}) begin
        failures++;
        $display("FAIL async_reset k=%0d: got clk_en=%b rst_n=%b done=%b busy=%b err=%b err_dom=%0d want 0 0000 0 1 0 0",
                 k, clk_en, dom_rst_n, seq_done, busy, err, err_dom);
      end
      #2 rst_n = 1'b1;
      run_seq('{1, 1, 1, 1}, 28, -1, "post_async_reset");
    end
  endtask

  task automatic test_random();
    int d[N];
    int done_t, sa;
    for (int k = 0; k < 10; k++) begin
      done_t = SETTLE + (N - 1) * GAP;
      for (int i = 0; i < N; i++) begin
        d[i]   = $urandom_range(1, 12);
        done_t = done_t + d[i];
      end
      if ($urandom_range(0, 1) == 1) sa = $urandom_range(0, done_t);
      else                           sa = done_t + $urandom_range(1, 6);
      run_seq(d, sa, -1, "random");
    end
  endtask

`ifdef RST_SEQ_TIMEOUT_EN
  // Domain 1 never acks: ERR 64 edges after its release, then soft recovery.
  task automatic test_timeout();
    int rel1, terr;
    logic [N-1:0] e_rst;
    rel1 = SETTLE + 1 + GAP;
    terr = rel1 + TO;
    for (int t = 0; t <= terr + 3; t++) begin
      dom_ack      = 4'b1101;
      soft_rst_req = 1'b0;
      @(posedge clk);
      #1;
      if (t >= terr) begin
        checks++;
        if ({err, err_dom, busy, seq_done, clk_en, dom_rst_n} !== {1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0011}) begin
          failures++;
          $display("FAIL timeout_err t=%0d: got err=%b err_dom=%0d busy=%b done=%b rst_n=%b want 1 1 0 0 0011",
                   t, err, err_dom, busy, seq_done, dom_rst_n);
        end
      end else if (t >= rel1) begin
        checks++;
        if ({err, busy, dom_rst_n} !== {1'b0, 1'b1, 4'b0011}) begin
          failures++;
          $display("FAIL timeout_wait t=%0d: got err=%b busy=%b rst_n=%b want 0 1 0011",
                   t, err, busy, dom_rst_n);
        end
      end
    end
    soft_rst_req = 1'b1;
    @(posedge clk);
    #1;
    soft_rst_req = 1'b0;
    checks++;
    if ({err, busy, seq_done} !== 3'b010) begin
      failures++;
      $display("FAIL timeout_recover: got err=%b busy=%b done=%b want 0 1 0", err, busy, seq_done);
    end
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) e_rst[i] = (i < 2) && (k < N - i);
      checks++;
      if ({clk_en, dom_rst_n} !== {(k < N + 1), e_rst}) begin
        failures++;
        $display("FAIL timeout_teardown k=%0d: got clk_en=%b rst_n=%b want %b %b",
                 k, clk_en, dom_rst_n, (k < N + 1), e_rst);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_timing();
    test_resequence();
    test_late_ack();
    test_soft_mid_seq();
    test_async_reset();
    test_random();
`ifdef RST_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOM, default 4, giving the number of reset domains (range 1..16).
REQ-002 The block SHALL have parameter CLK_SETTLE, default 8, giving the cycles between clk_en rising and release of domain 0 (range 1..255).
REQ-003 The block SHALL have parameter REL_GAP, default 4, giving the cycles between an ack of domain i and release of domain i+1 (range 1..255).
REQ-004 The block SHALL have parameter TO_CYC, default 64, giving the ack timeout in cycles; it is used only when RST_SEQ_TIMEOUT_EN is defined.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge clocked.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port soft_rst_req, input, 1 bit: request to re-run the full reset sequence.
REQ-008 The block SHALL have port dom_ack, input, NUM_DOM bits: bit i high means domain i reports ready after release.
REQ-009 The block SHALL have port clk_en, output, 1 bit: clock enable to the gated clock tree.
REQ-010 The block SHALL have port dom_rst_n, output, NUM_DOM bits: per-domain active-low reset.
REQ-011 The block SHALL have port seq_done, output, 1 bit: all domains released and acked.
REQ-012 The block SHALL have port busy, output, 1 bit: a sequence is in progress (any state except DONE and ERR).
REQ-013 The block SHALL have port err, output, 1 bit: ack timeout occurred.
REQ-014 The block SHALL have port err_dom, output, clog2(NUM_DOM) bits (minimum 1): index of the domain that timed out.

Function
REQ-015 The block SHALL implement the FSM states HOLD, SETTLE, WAIT_ACK, GAP, DONE, ASSERT and ERR, with a domain index idx.
REQ-016 HOLD SHALL last exactly one cycle with clk_en=0, then go to SETTLE with clk_en=1 and idx=0.
REQ-017 SETTLE SHALL count CLK_SETTLE cycles; on the edge ending the count, dom_rst_n[idx] SHALL go to 1 and the FSM SHALL enter WAIT_ACK.
REQ-018 In WAIT_ACK, only dom_ack[idx] SHALL be sampled; other ack bits SHALL be ignored.
REQ-019 On the edge sampling dom_ack[idx]=1: if idx<NUM_DOM-1, the FSM SHALL go to GAP; otherwise it SHALL go to DONE with seq_done=1 and busy=0 on that edge.
REQ-020 GAP SHALL last REL_GAP cycles, then increment idx, set dom_rst_n[idx]=1 and enter WAIT_ACK.
REQ-021 Released domains SHALL stay released until ASSERT; acks dropping after release SHALL be ignored.
REQ-022 soft_rst_req=1 sampled outside DONE and ERR SHALL set a pending flag, which is serviced on entering DONE (DONE lasts one cycle, with seq_done=1, before ASSERT).
REQ-023 Entering ASSERT from DONE or ERR at edge S0 SHALL clear seq_done and set busy on S0.
REQ-024 In ASSERT, dom_rst_n[NUM_DOM-1] SHALL go low at S0+1 and continue in descending order, one bit per cycle, to dom_rst_n[0] at S0+NUM_DOM.
REQ-025 After ASSERT, clk_en SHALL go low at S0+NUM_DOM+1 and the FSM SHALL enter HOLD, then re-sequence per REQ-016.
REQ-026 Already-low bits SHALL stay low during ASSERT (idempotent).
REQ-027 soft_rst_req and pending SHALL be ignored and cleared during ASSERT.
REQ-028 dom_rst_n bits with index > idx SHALL always be 0 outside ASSERT.

Reset
REQ-029 rst_n=0 SHALL immediately, regardless of clock, force clk_en=0, dom_rst_n=0, seq_done=0, busy=1, err=0, err_dom=0, pending=0, idx=0, counters=0, state=HOLD.
REQ-030 Reset asserted mid-sequence, in DONE or in ERR SHALL yield the same values as REQ-029; no partial state survives.
REQ-031 Sequencing SHALL begin on the first clk edge after rst_n rises.

Configuration
REQ-032 With RST_SEQ_TIMEOUT_EN defined, a WAIT_ACK counter SHALL reset on each WAIT_ACK entry.
REQ-033 With RST_SEQ_TIMEOUT_EN defined and TO_CYC cycles elapsed without ack, the FSM SHALL enter ERR with err=1, err_dom=idx, busy=0 and later domains held in reset.
REQ-034 With RST_SEQ_TIMEOUT_EN defined, ERR SHALL be left only by soft_rst_req (to ASSERT, clearing err at S0) or by rst_n.
REQ-035 Without RST_SEQ_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, err and err_dom SHALL be tied 0, and no timeout counter SHALL exist.

Verification
REQ-036 Defaults, dom_ack tied to 4'hF, rst_n released -> clk_en=1 at E0; dom_rst_n bits rise at E8, E13, E18, E23; seq_done=1 at E24.
REQ-037 dom_ack[2] delayed 20 cycles after its release -> dom_rst_n[3] rises exactly REL_GAP edges after the edge sampling ack[2]; no early release.
REQ-038 soft_rst_req pulse in DONE -> dom_rst_n reads 4'b0111, 0011, 0001, 0000 on consecutive edges, clk_en=0 the next edge, then the REQ-036 timing repeats.
REQ-039 soft_rst_req pulse at E10 -> sequence completes, seq_done high for one cycle, then ASSERT runs.
REQ-040 With RST_SEQ_TIMEOUT_EN, dom_ack[1] held 0 -> err=1 and err_dom=1 exactly 64 cycles after dom_rst_n[1] rises; dom_rst_n=4'b0011 holds.
REQ-041 rst_n pulsed low mid-GAP -> all outputs match the REQ-029 values asynchronously, before the next clk edge.
